// File: rtl/label_stream_packer_if.sv
// AXI-Stream style channel shared by the label input and the packed-word output.
interface label_stream_packer_if;
  logic [31:0] TDATA;
  logic        TVALID;
  logic        TREADY;
  logic        TLAST;

  modport master (output TDATA, TVALID, TLAST, input TREADY);
  modport slave  (input TDATA, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/label_stream_packer.sv
// Packs a stream of one-label-per-beat into four labels per 32-bit word,
// enforcing frame length and feeding a 2-entry output FIFO.
module label_stream_packer_lane #(
  parameter int IDX   = 0,
  parameter int VEC_W = 8
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             ld,
  input  logic [1:0]       lane_cnt,
  input  logic [VEC_W-1:0] label,
  output logic [VEC_W-1:0] lane_byte
);
  localparam logic [1:0] LI = 2'(IDX);
  logic [VEC_W-1:0] q;

  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET)                  q <= '0;
    else if (ld && lane_cnt == LI) q <= label;

  // Lanes not yet filled for the word being closed read as zero padding.
  always_comb begin
    lane_byte = '0;
    if (lane_cnt > LI)       lane_byte = q;
    else if (lane_cnt == LI) lane_byte = label;
  end
endmodule

module label_stream_packer #(
  parameter int LABELS_PER_FRAME = 64,
  parameter int LABEL_WIDTH      = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  label_stream_packer_if.slave  S_AXIS,
  label_stream_packer_if.master M_AXIS,
  output logic                  frame_err,
  output logic [15:0]           frames_done
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int CNT_W     = $clog2(LABELS_PER_FRAME);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LABELS_PER_FRAME - 1);

  typedef struct packed {
    logic [NUM_LANES-1:0][VEC_W-1:0] data;
    logic                            last;
  } entry_t;

  entry_t                          fifo [2];
  logic                            wr_ptr, rd_ptr, s_rdy;
  logic [1:0]                      cnt, cnt_nxt, lane_cnt;
  logic [CNT_W-1:0]                label_cnt;
  logic [VEC_W-1:0]                label;
  logic                            accept, pop, at_end, close, push;
  logic [NUM_LANES-1:0][VEC_W-1:0] word;

  assign label   = VEC_W'(S_AXIS.TDATA[LABEL_WIDTH-1:0]);
  assign accept  = S_AXIS.TVALID & s_rdy;
  assign pop     = (cnt != 2'd0) & M_AXIS.TREADY;
  assign at_end  = (label_cnt == LAST_IDX);
  assign close   = S_AXIS.TLAST | at_end;
  assign push    = accept & ((lane_cnt == 2'd3) | close);
  assign cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      label_stream_packer_lane #(.IDX(g), .VEC_W(VEC_W)) u_lane (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .ld        (accept),
        .lane_cnt  (lane_cnt),
        .label     (label),
        .lane_byte (word[g])
      );
    end
  endgenerate

  assign S_AXIS.TREADY = s_rdy;
  assign M_AXIS.TVALID = (cnt != 2'd0);
  assign M_AXIS.TDATA  = fifo[rd_ptr].data;
  assign M_AXIS.TLAST  = fifo[rd_ptr].last;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      cnt         <= 2'd0;
      s_rdy       <= 1'b0;
      lane_cnt    <= 2'd0;
      label_cnt   <= '0;
      frame_err   <= 1'b0;
      frames_done <= 16'd0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{data: word, last: close};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (fifo[rd_ptr].last) frames_done <= frames_done + 16'd1;
      end
      cnt   <= cnt_nxt;
      s_rdy <= (cnt_nxt < 2'd2);
      if (accept) begin
        lane_cnt  <= push  ? 2'd0 : lane_cnt + 2'd1;
        label_cnt <= close ? '0   : label_cnt + 1'b1;
        // Early TLAST or missing TLAST: exactly one of the two close causes.
        if (close && (S_AXIS.TLAST ^ at_end)) frame_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_label_stream_packer.sv
// Randomized and directed bench for label_stream_packer with a queue-based frame model.
module tb_label_stream_packer;
  localparam int LPF = 64;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        frame_err;
  logic [15:0] frames_done;

  label_stream_packer_if S();
  label_stream_packer_if M();

  label_stream_packer #(.LABELS_PER_FRAME(LPF), .LABEL_WIDTH(8)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .S_AXIS      (S),
    .M_AXIS      (M),
    .frame_err   (frame_err),
    .frames_done (frames_done)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed { logic [31:0] d; logic l; } wd_t;

  int total = 0, bad = 0;
  bit fix_rdy = 1'b1, rand_rdy = 1'b0;

  // Reference model: labels of the current word, position in frame, expectations.
  byte unsigned buf_q[$];
  int  nlab = 0, exp_frames = 0;
  bit  exp_err = 1'b0;
  wd_t exp_q[$], got_q[$];
  wd_t e, w, prev_w;
  bit  prev_hold = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_accept(input logic [31:0] d, input logic l);
    logic [31:0] wd;
    bit close;
    buf_q.push_back(d[7:0]);
    nlab++;
    close = l || (nlab == LPF);
    if (close && (l != (nlab == LPF))) exp_err = 1'b1;
    if (buf_q.size() == 4 || close) begin
      wd = '0;
      foreach (buf_q[i]) wd[8*i +: 8] = buf_q[i];
      exp_q.push_back('{d: wd, l: close});
      buf_q.delete();
    end
    if (close) nlab = 0;
  endtask

  // Single compare process: observes both handshakes between clock edges.
  always @(negedge ACLK) begin
    if (ARESET) begin
      buf_q.delete(); exp_q.delete();
      nlab = 0; exp_frames = 0; exp_err = 1'b0; prev_hold = 1'b0;
    end else begin
      chk("frame_err", {63'd0, frame_err}, {63'd0, exp_err});
      chk("frames_done", {48'd0, frames_done}, {48'd0, 16'(exp_frames)});
      if (prev_hold) begin
        chk("hold_valid", {63'd0, M.TVALID}, 64'd1);
        chk("hold_word", {31'd0, M.TDATA, M.TLAST}, {31'd0, prev_w});
      end
      if (M.TVALID && M.TREADY) begin
        w = '{d: M.TDATA, l: M.TLAST};
        got_q.push_back(w);
        if (exp_q.size() == 0) chk("unexpected_word", {31'd0, w}, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("word", {31'd0, w}, {31'd0, e});
          if (e.l) exp_frames++;
        end
      end
      prev_hold = M.TVALID && !M.TREADY;
      prev_w    = '{d: M.TDATA, l: M.TLAST};
      if (S.TVALID && S.TREADY) model_accept(S.TDATA, S.TLAST);
    end
  end

  initial begin
    M.TREADY = 1'b0;
    forever begin
      @(posedge ACLK); #1;
      M.TREADY = rand_rdy ? ($urandom_range(0, 3) != 0) : fix_rdy;
    end
  end

  task automatic do_reset();
    @(posedge ACLK); #1;
    ARESET = 1'b1; S.TVALID = 1'b0; S.TLAST = 1'b0;
    #2;
    chk("rst_s_tready", {63'd0, S.TREADY}, 64'd0);
    chk("rst_m_tvalid", {63'd0, M.TVALID}, 64'd0);
    chk("rst_m_tdata",  {32'd0, M.TDATA},  64'd0);
    chk("rst_m_tlast",  {63'd0, M.TLAST},  64'd0);
    chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
    chk("rst_frames_done", {48'd0, frames_done}, 64'd0);
    repeat (2) @(posedge ACLK);
    #1; ARESET = 1'b0;
    got_q.delete();
  endtask

  task automatic send(input logic [31:0] d, input logic l, input int gap);
    int t;
    repeat (gap) begin S.TVALID = 1'b0; @(posedge ACLK); #1; end
    S.TVALID = 1'b1; S.TDATA = d; S.TLAST = l;
    t = 0;
    @(negedge ACLK);
    while (!S.TREADY && t < 1000) begin @(negedge ACLK); t++; end
    if (t >= 1000) chk("send_timeout", 64'd1, 64'd0);
    @(posedge ACLK); #1;
    S.TVALID = 1'b0; S.TLAST = 1'b0;
  endtask

  task automatic drain();
    int idle = 0, t = 0;
    while (idle < 4 && t < 2000) begin
      @(negedge ACLK);
      idle = M.TVALID ? 0 : idle + 1;
      t++;
    end
    if (t >= 2000) chk("drain_timeout", 64'd1, 64'd0);
    @(posedge ACLK); #1;
  endtask

  initial begin
    int idx;
    bit acc;
    S.TVALID = 1'b0; S.TDATA = '0; S.TLAST = 1'b0;
    do_reset();

    // Nominal frame
    for (int i = 0; i < 64; i++) send(32'(i), i == 63, 0);
    drain();
    chk("nom_count", 64'(got_q.size()), 64'd16);
    chk("nom_first", {31'd0, got_q[0]},  {31'd0, 32'h03020100, 1'b0});
    chk("nom_last",  {31'd0, got_q[15]}, {31'd0, 32'h3F3E3D3C, 1'b1});
    chk("nom_frames", {48'd0, frames_done}, 64'd1);
    chk("nom_err", {63'd0, frame_err}, 64'd0);

    // Upper-bit masking
    do_reset();
    send(32'hFFFFFF01, 1'b0, 0); send(32'hABCDEF02, 1'b0, 0);
    send(32'h00000003, 1'b0, 0); send(32'h00000004, 1'b0, 0);
    drain();
    chk("mask_word", {31'd0, got_q[0]}, {31'd0, 32'h04030201, 1'b0});

    // Early TLAST
    do_reset();
    for (int i = 0; i < 6; i++) send(32'h11 + 32'(i), i == 5, 0);
    drain();
    chk("early_count", 64'(got_q.size()), 64'd2);
    chk("early_w0", {31'd0, got_q[0]}, {31'd0, 32'h14131211, 1'b0});
    chk("early_w1", {31'd0, got_q[1]}, {31'd0, 32'h00001615, 1'b1});
    chk("early_err", {63'd0, frame_err}, 64'd1);
    chk("early_frames", {48'd0, frames_done}, 64'd1);

    // Missing TLAST
    do_reset();
    for (int i = 0; i < 68; i++) send(32'(i), 1'b0, 0);
    drain();
    chk("miss_count", 64'(got_q.size()), 64'd17);
    chk("miss_w15", {31'd0, got_q[15]}, {31'd0, 32'h3F3E3D3C, 1'b1});
    chk("miss_w16", {31'd0, got_q[16]}, {31'd0, 32'h43424140, 1'b0});
    chk("miss_err", {63'd0, frame_err}, 64'd1);
    chk("miss_frames", {48'd0, frames_done}, 64'd1);

    // Backpressure: exactly 8 labels absorbed with the output stalled
    fix_rdy = 1'b0;
    do_reset();
    idx = 0;
    S.TVALID = 1'b1; S.TDATA = 32'(idx); S.TLAST = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge ACLK);
      acc = S.TREADY;
      @(posedge ACLK); #1;
      if (acc) begin idx++; S.TDATA = 32'(idx); S.TLAST = (idx == 63); end
    end
    chk("bp_accepted", 64'(idx), 64'd8);
    chk("bp_tready_low", {63'd0, S.TREADY}, 64'd0);
    S.TVALID = 1'b0;
    fix_rdy = 1'b1;
    for (int i = idx; i < 64; i++) send(32'(i), i == 63, 0);
    drain();
    chk("bp_count", 64'(got_q.size()), 64'd16);
    chk("bp_w2", {31'd0, got_q[2]}, {31'd0, 32'h0B0A0908, 1'b0});
    chk("bp_frames", {48'd0, frames_done}, 64'd1);

    // Reset mid-frame
    do_reset();
    for (int i = 0; i < 30; i++) send(32'h80 + 32'(i), 1'b0, 0);
    do_reset();
    for (int i = 0; i < 64; i++) send(32'(i), i == 63, 0);
    drain();
    chk("rmid_count", 64'(got_q.size()), 64'd16);
    chk("rmid_first", {31'd0, got_q[0]}, {31'd0, 32'h03020100, 1'b0});
    chk("rmid_frames", {48'd0, frames_done}, 64'd1);
    chk("rmid_err", {63'd0, frame_err}, 64'd0);

    // Randomized traffic with random gaps, TLAST and output stalls
    do_reset();
    rand_rdy = 1'b1;
    for (int n = 0; n < 1500; n++)
      send($urandom, $urandom_range(0, 40) == 0, ($urandom_range(0, 2) == 0) ? 1 : 0);
    drain();
    rand_rdy = 1'b0;
    chk("rand_model_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
